// File: rtl/audio_softmute_pkg.sv
// Shared types and constants for the audio soft-mute stage.
// The optional DC-blocking filter is enabled with the AUDIO_DCBLOCK_EN macro.
package audio_softmute_pkg;

   localparam int SAMPLE_W  = 16;
   localparam int GAIN_W    = 9;
   localparam int PROD_W    = 25;
   localparam int DCB_ACC_W = 18;

   localparam logic [GAIN_W-1:0] GAIN_UNITY = 9'd256;

   localparam logic [2:0] ST_MUTED = 3'd0;
   localparam logic [2:0] ST_HOLD  = 3'd1;
   localparam logic [2:0] ST_UP    = 3'd2;
   localparam logic [2:0] ST_PASS  = 3'd3;
   localparam logic [2:0] ST_DOWN  = 3'd4;

   typedef enum logic [2:0] {
      MUTED = ST_MUTED,
      HOLD  = ST_HOLD,
      UP    = ST_UP,
      PASS  = ST_PASS,
      DOWN  = ST_DOWN
   } state_e;

endpackage

// File: rtl/audio_dcblock.sv
// One-channel DC-blocking high-pass: y[n] = x[n] - x[n-1] + y[n-1] - (y[n-1] >>> 10).
// Used by audio_softmute only when AUDIO_DCBLOCK_EN is defined.
module audio_dcblock
   import audio_softmute_pkg::*;
(
   input  logic                clk_sys,
   input  logic                reset_n,
   input  logic                ce,
   input  logic [SAMPLE_W-1:0] x,
   output logic [SAMPLE_W-1:0] y
);

   localparam int SUM_W = DCB_ACC_W + 2;
   localparam logic signed [SUM_W-1:0]     ACC_MAX = SUM_W'((1 << (DCB_ACC_W - 1)) - 1);
   localparam logic signed [SUM_W-1:0]     ACC_MIN = SUM_W'(-(1 << (DCB_ACC_W - 1)));
   localparam logic signed [DCB_ACC_W-1:0] OUT_MAX = DCB_ACC_W'(32767);
   localparam logic signed [DCB_ACC_W-1:0] OUT_MIN = DCB_ACC_W'(-32768);

   function automatic logic signed [DCB_ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
      if (v > ACC_MAX) return DCB_ACC_W'(ACC_MAX);
      if (v < ACC_MIN) return DCB_ACC_W'(ACC_MIN);
      return DCB_ACC_W'(v);
   endfunction

   function automatic logic [SAMPLE_W-1:0] sat_out(input logic signed [DCB_ACC_W-1:0] v);
      if (v > OUT_MAX) return SAMPLE_W'(OUT_MAX);
      if (v < OUT_MIN) return SAMPLE_W'(OUT_MIN);
      return SAMPLE_W'(v);
   endfunction

   logic signed [SAMPLE_W-1:0]  x_prev_q, x_prev_d;
   logic signed [DCB_ACC_W-1:0] acc_q, acc_d;
   logic        [SAMPLE_W-1:0]  y_q, y_d;
   logic signed [SUM_W-1:0]     sum;

   assign sum = SUM_W'($signed(x)) - SUM_W'(x_prev_q) + SUM_W'(acc_q) - SUM_W'(acc_q >>> 10);

   always_comb begin
      x_prev_d = x_prev_q;
      acc_d    = acc_q;
      y_d      = y_q;
      if (ce) begin
         x_prev_d = $signed(x);
         acc_d    = sat_acc(sum);
         y_d      = sat_out(sat_acc(sum));
      end
   end

   // Filter history survives mute; only reset clears it.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         x_prev_q <= '0;
         acc_q    <= '0;
         y_q      <= '0;
      end else begin
         x_prev_q <= x_prev_d;
         acc_q    <= acc_d;
         y_q      <= y_d;
      end
   end

   assign y = y_q;

endmodule

// File: rtl/audio_softmute.sv
// Click-free mute for the stereo audio path: fade down, silent hold, fade up to unity.
// Define AUDIO_DCBLOCK_EN to insert a per-channel DC-blocking filter ahead of the gain stage.
module audio_softmute
   import audio_softmute_pkg::*;
#(
   parameter int HOLD_SAMPLES = 4096,
   parameter int RAMP_DIV     = 64
) (
   input  logic                clk_sys,
   input  logic                reset_n,
   input  logic                sample_ce,
   input  logic                mute_req,
   input  logic [SAMPLE_W-1:0] in_l,
   input  logic [SAMPLE_W-1:0] in_r,
   output logic [SAMPLE_W-1:0] out_l,
   output logic [SAMPLE_W-1:0] out_r,
   output logic                out_valid,
   output logic                muted
);

   localparam int HOLD_W = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
   localparam int DIV_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_SAMPLES - 1);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(RAMP_DIV - 1);

   // Floor of (s * g) / 256; exact for g == 256, zero for g == 0.
   function automatic logic [SAMPLE_W-1:0] apply_gain(input logic [SAMPLE_W-1:0] s,
                                                     input logic [GAIN_W-1:0]   g);
      logic signed [PROD_W-1:0] s_x;
      logic signed [PROD_W-1:0] g_x;
      logic signed [PROD_W-1:0] prod;
      s_x  = PROD_W'($signed(s));
      g_x  = $signed(PROD_W'(g));
      prod = s_x * g_x;
      return SAMPLE_W'(prod >>> 8);
   endfunction

   state_e              state_q, state_d;
   logic [GAIN_W-1:0]   gain_q, gain_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [DIV_W-1:0]    div_q, div_d;

   logic                vld_p0_q, vld_p0_d;
   logic [SAMPLE_W-1:0] in_l_p0_q, in_l_p0_d;
   logic [SAMPLE_W-1:0] in_r_p0_q, in_r_p0_d;
   logic [GAIN_W-1:0]   gain_p0_q, gain_p0_d;

   logic                mul_vld;
   logic [SAMPLE_W-1:0] mul_l, mul_r;
   logic [GAIN_W-1:0]   mul_gain;

   logic [SAMPLE_W-1:0] out_l_q, out_l_d;
   logic [SAMPLE_W-1:0] out_r_q, out_r_d;
   logic                out_valid_q, out_valid_d;
   logic                muted_q, muted_d;

   always_comb begin
      state_d = state_q;
      gain_d  = gain_q;
      hold_d  = hold_q;
      div_d   = div_q;
      if (sample_ce) begin
         case (state_q)
            MUTED: begin
               gain_d = '0;
               if (!mute_req) begin
                  state_d = HOLD;
                  hold_d  = '0;
                  div_d   = '0;
               end
            end
            HOLD: begin
               if (mute_req) begin
                  state_d = MUTED;
                  div_d   = '0;
               end else if (hold_q == HOLD_LAST) begin
                  state_d = UP;
                  div_d   = '0;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
            UP: begin
               // A mute request wins over reaching unity on the same sample.
               if (mute_req) begin
                  state_d = DOWN;
                  div_d   = '0;
               end else if (div_q == DIV_LAST) begin
                  div_d  = '0;
                  gain_d = gain_q + 1'b1;
                  if (gain_q == GAIN_UNITY - 1'b1) state_d = PASS;
               end else begin
                  div_d = div_q + 1'b1;
               end
            end
            PASS: begin
               gain_d = GAIN_UNITY;
               if (mute_req) begin
                  state_d = DOWN;
                  div_d   = '0;
               end
            end
            DOWN: begin
               if (div_q == DIV_LAST) begin
                  div_d = '0;
                  if (gain_q <= GAIN_W'(1)) begin
                     gain_d  = '0;
                     state_d = MUTED;
                  end else begin
                     gain_d = gain_q - 1'b1;
                  end
               end else begin
                  div_d = div_q + 1'b1;
               end
            end
            default: begin
               state_d = MUTED;
               gain_d  = '0;
               div_d   = '0;
            end
         endcase
      end
   end

   // Stage p0: capture inputs with the gain in force before this sample's update.
   always_comb begin
      vld_p0_d  = sample_ce;
      in_l_p0_d = sample_ce ? in_l   : in_l_p0_q;
      in_r_p0_d = sample_ce ? in_r   : in_r_p0_q;
      gain_p0_d = sample_ce ? gain_q : gain_p0_q;
   end

`ifdef AUDIO_DCBLOCK_EN
   logic                vld_p1_q, vld_p1_d;
   logic [GAIN_W-1:0]   gain_p1_q, gain_p1_d;
   logic [SAMPLE_W-1:0] dcb_l, dcb_r;

   // Stage p1: DC-blocking filter, gain travels alongside.
   audio_dcblock u_dcb_l (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .ce      (vld_p0_q),
      .x       (in_l_p0_q),
      .y       (dcb_l)
   );

   audio_dcblock u_dcb_r (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .ce      (vld_p0_q),
      .x       (in_r_p0_q),
      .y       (dcb_r)
   );

   always_comb begin
      vld_p1_d  = vld_p0_q;
      gain_p1_d = vld_p0_q ? gain_p0_q : gain_p1_q;
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) vld_p1_q <= 1'b0;
      else          vld_p1_q <= vld_p1_d;
   end

   always_ff @(posedge clk_sys) gain_p1_q <= gain_p1_d;

   assign mul_vld  = vld_p1_q;
   assign mul_l    = dcb_l;
   assign mul_r    = dcb_r;
   assign mul_gain = gain_p1_q;
`else
   assign mul_vld  = vld_p0_q;
   assign mul_l    = in_l_p0_q;
   assign mul_r    = in_r_p0_q;
   assign mul_gain = gain_p0_q;
`endif

   // Output stage: multiply, shift, hold between samples.
   always_comb begin
      out_l_d     = mul_vld ? apply_gain(mul_l, mul_gain) : out_l_q;
      out_r_d     = mul_vld ? apply_gain(mul_r, mul_gain) : out_r_q;
      out_valid_d = mul_vld;
      muted_d     = (gain_q == '0);
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state_q     <= MUTED;
         gain_q      <= '0;
         hold_q      <= '0;
         div_q       <= '0;
         vld_p0_q    <= 1'b0;
         out_l_q     <= '0;
         out_r_q     <= '0;
         out_valid_q <= 1'b0;
         muted_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         gain_q      <= gain_d;
         hold_q      <= hold_d;
         div_q       <= div_d;
         vld_p0_q    <= vld_p0_d;
         out_l_q     <= out_l_d;
         out_r_q     <= out_r_d;
         out_valid_q <= out_valid_d;
         muted_q     <= muted_d;
      end
   end

   always_ff @(posedge clk_sys) begin
      in_l_p0_q <= in_l_p0_d;
      in_r_p0_q <= in_r_p0_d;
      gain_p0_q <= gain_p0_d;
   end

   assign out_l     = out_l_q;
   assign out_r     = out_r_q;
   assign out_valid = out_valid_q;
   assign muted     = muted_q;

endmodule

// File: tb/tb_audio_softmute.sv
// Self-checking bench for audio_softmute: vector tables plus a reference-model scoreboard.
module tb_audio_softmute;

   localparam int HOLD    = 4;
   localparam int RDIV    = 2;
   localparam int SPACING = 8;
`ifdef AUDIO_DCBLOCK_EN
   localparam int LAT    = 3;
   localparam bit TBL_OK = 1'b0;
`else
   localparam int LAT    = 2;
   localparam bit TBL_OK = 1'b1;
`endif

   localparam int S_MUT = 0, S_HOLD = 1, S_UP = 2, S_PASS = 3, S_DOWN = 4;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        sample_ce;
   logic        mute_req;
   logic [15:0] in_l, in_r;
   logic [15:0] out_l, out_r;
   logic        out_valid;
   logic        muted;

   audio_softmute #(.HOLD_SAMPLES(HOLD), .RAMP_DIV(RDIV)) dut (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .sample_ce (sample_ce),
      .mute_req  (mute_req),
      .in_l      (in_l),
      .in_r      (in_r),
      .out_l     (out_l),
      .out_r     (out_r),
      .out_valid (out_valid),
      .muted     (muted)
   );

   always #5 clk_sys = ~clk_sys;

   int cyc = 0;
   always @(posedge clk_sys) cyc <= cyc + 1;

   typedef struct {
      int l;
      int r;
      bit m;
      int due;
   } exp_t;

   typedef struct {
      int l;
      int r;
      int el;
      int er;
   } vec_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;

   int m_state, m_gain, m_hold, m_div;
   int f_xp_l, f_y_l, f_xp_r, f_y_r;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic int gmul(input int s, input int g);
      return (s * g) >>> 8;
   endfunction

   function automatic int clamp(input int v, input int lo, input int hi);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   task automatic dcb(inout int xp, inout int y, input int x, output int o);
      int s;
      s  = clamp(x - xp + y - (y >>> 10), -131072, 131071);
      y  = s;
      xp = x;
      o  = clamp(s, -32768, 32767);
   endtask

   task automatic model_reset();
      m_state = S_MUT; m_gain = 0; m_hold = 0; m_div = 0;
      f_xp_l = 0; f_y_l = 0; f_xp_r = 0; f_y_r = 0;
   endtask

   task automatic model_step(input bit mreq);
      case (m_state)
         S_MUT: begin
            m_gain = 0;
            if (!mreq) begin m_state = S_HOLD; m_hold = 0; m_div = 0; end
         end
         S_HOLD: begin
            if (mreq)                   begin m_state = S_MUT; m_div = 0; end
            else if (m_hold == HOLD-1)  begin m_state = S_UP;  m_div = 0; end
            else                        m_hold++;
         end
         S_UP: begin
            if (mreq) begin m_state = S_DOWN; m_div = 0; end
            else if (++m_div == RDIV) begin
               m_div = 0;
               m_gain++;
               if (m_gain == 256) m_state = S_PASS;
            end
         end
         S_PASS: begin
            m_gain = 256;
            if (mreq) begin m_state = S_DOWN; m_div = 0; end
         end
         default: begin
            if (++m_div == RDIV) begin
               m_div = 0;
               m_gain--;
               if (m_gain == 0) m_state = S_MUT;
            end
         end
      endcase
   endtask

   // One sample strobe; the expectation is queued at the moment the strobe is driven.
   task automatic send(input int l, input int r, input bit mreq,
                       input bit use_tbl, input int el, input int er);
      exp_t e;
      int   fl, fr, g;
      @(posedge clk_sys); #1;
      sample_ce = 1'b1;
      in_l      = 16'(l);
      in_r      = 16'(r);
      mute_req  = mreq;
      fl = l; fr = r;
`ifdef AUDIO_DCBLOCK_EN
      dcb(f_xp_l, f_y_l, l, fl);
      dcb(f_xp_r, f_y_r, r, fr);
`endif
      g = m_gain;
      model_step(mreq);
      e.l   = use_tbl ? el : gmul(fl, g);
      e.r   = use_tbl ? er : gmul(fr, g);
      e.m   = (m_gain == 0);
      e.due = cyc + LAT;
      sbq.push_back(e);
      @(posedge clk_sys); #1;
      sample_ce = 1'b0;
      repeat (SPACING - 2) @(posedge clk_sys);
   endtask

   always @(negedge clk_sys) begin
      if (sbq.size() > 0 && cyc > sbq[0].due) begin
         checks++;
         errors++;
         $display("FAIL out_valid_missing: none by cycle %0d, expected at %0d", cyc, sbq[0].due);
         void'(sbq.pop_front());
      end
      if (out_valid) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_valid_unexpected: pulse at cycle %0d, expected none", cyc);
         end else begin
            mon_e = sbq.pop_front();
            check("out_l", $signed(out_l), mon_e.l);
            check("out_r", $signed(out_r), mon_e.r);
            check("latency_cycle", cyc, mon_e.due);
            check("muted", int'(muted), int'(mon_e.m));
         end
      end
   end

   vec_t half_tbl[2];
   vec_t unity_tbl[4];

   initial begin
      half_tbl[0]  = '{l: -1,     r: 32767,  el: -1,     er: 16383};
      half_tbl[1]  = '{l: -32768, r: 255,    el: -16384, er: 127};
      unity_tbl[0] = '{l: 1000,   r: -1000,  el: 1000,   er: -1000};
      unity_tbl[1] = '{l: 32767,  r: -32768, el: 32767,  er: -32768};
      unity_tbl[2] = '{l: -1,     r: 1,      el: -1,     er: 1};
      unity_tbl[3] = '{l: 0,      r: 12345,  el: 0,      er: 12345};

      reset_n = 1'b0; sample_ce = 1'b0; mute_req = 1'b0; in_l = '0; in_r = '0;
      model_reset();
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      check("rst_out_l", int'(out_l), 0);
      check("rst_out_r", int'(out_r), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_muted", int'(muted), 1);
      @(posedge clk_sys); #1;
      reset_n = 1'b1;

      // Release: MUTED, 4 HOLD samples, then ramp; samples 262/263 carry gain 128.
      for (int k = 1; k <= 261; k++) send(1000, -1000, 1'b0, 1'b0, 0, 0);
      for (int i = 0; i < 2; i++)
         send(half_tbl[i].l, half_tbl[i].r, 1'b0, TBL_OK, half_tbl[i].el, half_tbl[i].er);
      for (int k = 264; k <= 517; k++) send(1000, -1000, 1'b0, 1'b0, 0, 0);
      for (int i = 0; i < 4; i++)
         send(unity_tbl[i].l, unity_tbl[i].r, 1'b0, TBL_OK, unity_tbl[i].el, unity_tbl[i].er);

      // Mute from PASS: one PASS sample then 512 fade samples.
      for (int k = 0; k < 513; k++) send(1000, -1000, 1'b1, 1'b0, 0, 0);
      @(negedge clk_sys);
      check("muted_after_fade", int'(muted), 1);
      send(-32768, -32768, 1'b1, 1'b1, 0, 0);

      // Short ramp up, then mute with a 2-sample low pulse inside the fade.
      for (int k = 0; k < 25; k++) send(2000, 3000, 1'b0, 1'b0, 0, 0);
      for (int k = 0; k < 4; k++)  send(2000, 3000, 1'b1, 1'b0, 0, 0);
      for (int k = 0; k < 2; k++)  send(2000, 3000, 1'b0, 1'b0, 0, 0);
      for (int k = 0; k < 30; k++) send(2000, 3000, 1'b1, 1'b0, 0, 0);
      @(negedge clk_sys);
      check("muted_after_pulsed_fade", int'(muted), 1);
      for (int k = 0; k < 12; k++) send(2000, 3000, 1'b0, 1'b0, 0, 0);

      // Ramp on to gain 100, then reset with a sample in flight.
      for (int k = 0; k < 400 && !(m_state == S_UP && m_gain == 100); k++)
         send(4000, -4000, 1'b0, 1'b0, 0, 0);
      @(posedge clk_sys); #1;
      sample_ce = 1'b1; in_l = 16'd5000; in_r = 16'd5000;
      @(posedge clk_sys); #1;
      sample_ce = 1'b0; reset_n = 1'b0;
      @(posedge clk_sys); #1;
      reset_n = 1'b1;
      model_reset();
      @(negedge clk_sys);
      check("midrst_out_l", int'(out_l), 0);
      check("midrst_out_r", int'(out_r), 0);
      check("midrst_out_valid", int'(out_valid), 0);
      check("midrst_muted", int'(muted), 1);
      repeat (4) @(posedge clk_sys);
      for (int k = 0; k < 10; k++) send(1000, -1000, 1'b0, 1'b0, 0, 0);

      repeat (4 * SPACING) @(posedge clk_sys);
      @(negedge clk_sys);
      check("scoreboard_drained", sbq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
